mem_stage_access: RTL and testbench

- MEM-stage consumer of the EX/MEM pipeline register outputs. Evaluates the ARM condition code against an architectural NZCV flags register.
- Runs conditional loads/stores to data memory over a req/ack handshake and stalls the upstream pipeline while an access is outstanding.
- Registers the MEM/WB stage outputs for the register-file writeback.

---
 rtl/mem_stage_access.sv | 227 ++++++++++++++++++++++
 tb/tb_mem_stage_access.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_access.sv
// rtl/mem_stage_access.sv - MEM stage: condition check, NZCV register, data-memory handshake, MEM/WB register
// Conditional loads/stores hold the pipeline in WAIT until mem_ack or a MAX_WAIT timeout.
module mem_stage_access #(
   parameter int MAX_WAIT = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        PCSrcM,
   input  logic        RegWriteM,
   input  logic        MemtoRegM,
   input  logic        MemWriteM,
   input  logic        FlagsWriteM,
   input  logic [31:0] ALUOutM,
   input  logic [31:0] WriteDataM,
   input  logic [31:0] PCM,
   input  logic [3:0]  WA3M,
   input  logic [3:0]  CondM,
   input  logic [3:0]  ALUFlagsM,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack,
   output logic        stallM,
   output logic [3:0]  FlagsQ,
   output logic        PCSrcW,
   output logic        RegWriteW,
   output logic        MemtoRegW,
   output logic [31:0] ReadDataW,
   output logic [31:0] ALUOutW,
   output logic [31:0] PCW,
   output logic [3:0]  WA3W,
   output logic        mem_err
);

   localparam int CW = $clog2(MAX_WAIT) + 1;
   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_WAIT = 1'b1;

   logic [0:0]    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          mem_req_q, mem_req_d;
   logic          mem_we_q, mem_we_d;
   logic [31:0]   mem_addr_q, mem_addr_d;
   logic [31:0]   mem_wdata_q, mem_wdata_d;
   logic [3:0]    flags_q, flags_d;
   logic          mem_err_q, mem_err_d;
   logic          cap_pcsrc_q, cap_pcsrc_d;
   logic          cap_regwrite_q, cap_regwrite_d;
   logic          cap_memtoreg_q, cap_memtoreg_d;
   logic [31:0]   cap_pc_q, cap_pc_d;
   logic [3:0]    cap_wa3_q, cap_wa3_d;
   logic          pcsrc_w_q, pcsrc_w_d;
   logic          regwrite_w_q, regwrite_w_d;
   logic          memtoreg_w_q, memtoreg_w_d;
   logic [31:0]   readdata_w_q, readdata_w_d;
   logic [31:0]   aluout_w_q, aluout_w_d;
   logic [31:0]   pc_w_q, pc_w_d;
   logic [3:0]    wa3_w_q, wa3_w_d;

   logic cond_ex;
   logic acc;
   logic fn, fz, fc, fv;

   assign fn = flags_q[3];
   assign fz = flags_q[2];
   assign fc = flags_q[1];
   assign fv = flags_q[0];

   always_comb begin
      cond_ex = 1'b0;
      case (CondM)
         4'b0000: cond_ex = fz;
         4'b0001: cond_ex = ~fz;
         4'b0010: cond_ex = fc;
         4'b0011: cond_ex = ~fc;
         4'b0100: cond_ex = fn;
         4'b0101: cond_ex = ~fn;
         4'b0110: cond_ex = fv;
         4'b0111: cond_ex = ~fv;
         4'b1000: cond_ex = fc & ~fz;
         4'b1001: cond_ex = ~fc | fz;
         4'b1010: cond_ex = (fn == fv);
         4'b1011: cond_ex = (fn != fv);
         4'b1100: cond_ex = ~fz & (fn == fv);
         4'b1101: cond_ex = fz | (fn != fv);
         4'b1110: cond_ex = 1'b1;
         default: cond_ex = 1'b0;
      endcase
   end

   assign acc    = cond_ex & (MemWriteM | MemtoRegM);
   assign stallM = ((state_q == ST_IDLE) & acc) | (state_q == ST_WAIT);

   // WB registers reload every cycle; anything not explicitly loaded becomes a bubble.
   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      mem_req_d      = mem_req_q;
      mem_we_d       = mem_we_q;
      mem_addr_d     = mem_addr_q;
      mem_wdata_d    = mem_wdata_q;
      flags_d        = flags_q;
      mem_err_d      = mem_err_q;
      cap_pcsrc_d    = cap_pcsrc_q;
      cap_regwrite_d = cap_regwrite_q;
      cap_memtoreg_d = cap_memtoreg_q;
      cap_pc_d       = cap_pc_q;
      cap_wa3_d      = cap_wa3_q;
      pcsrc_w_d      = 1'b0;
      regwrite_w_d   = 1'b0;
      memtoreg_w_d   = 1'b0;
      readdata_w_d   = 32'd0;
      aluout_w_d     = 32'd0;
      pc_w_d         = 32'd0;
      wa3_w_d        = 4'd0;
      case (state_q)
         ST_IDLE: begin
            if (FlagsWriteM & cond_ex) begin
               flags_d = ALUFlagsM;
            end
            if (acc) begin
               mem_req_d      = 1'b1;
               mem_we_d       = MemWriteM;
               mem_addr_d     = ALUOutM;
               mem_wdata_d    = WriteDataM;
               cap_pcsrc_d    = PCSrcM;
               cap_regwrite_d = RegWriteM;
               cap_memtoreg_d = MemtoRegM;
               cap_pc_d       = PCM;
               cap_wa3_d      = WA3M;
               cnt_d          = '0;
               state_d        = ST_WAIT;
            end else begin
               pcsrc_w_d    = PCSrcM & cond_ex;
               regwrite_w_d = RegWriteM & cond_ex;
               aluout_w_d   = ALUOutM;
               pc_w_d       = PCM;
               wa3_w_d      = WA3M;
            end
         end
         default: begin
            if (mem_ack) begin
               mem_req_d    = 1'b0;
               mem_we_d     = 1'b0;
               pcsrc_w_d    = cap_pcsrc_q;
               regwrite_w_d = cap_regwrite_q;
               memtoreg_w_d = cap_memtoreg_q;
               readdata_w_d = mem_we_q ? 32'd0 : mem_rdata;
               aluout_w_d   = mem_addr_q;
               pc_w_d       = cap_pc_q;
               wa3_w_d      = cap_wa3_q;
               state_d      = ST_IDLE;
            end else if (cnt_q == CW'(MAX_WAIT - 1)) begin
               mem_req_d = 1'b0;
               mem_we_d  = 1'b0;
               mem_err_d = 1'b1;
               state_d   = ST_IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= ST_IDLE;
         cnt_q          <= '0;
         mem_req_q      <= 1'b0;
         mem_we_q       <= 1'b0;
         mem_addr_q     <= 32'd0;
         mem_wdata_q    <= 32'd0;
         flags_q        <= 4'd0;
         mem_err_q      <= 1'b0;
         cap_pcsrc_q    <= 1'b0;
         cap_regwrite_q <= 1'b0;
         cap_memtoreg_q <= 1'b0;
         cap_pc_q       <= 32'd0;
         cap_wa3_q      <= 4'd0;
         pcsrc_w_q      <= 1'b0;
         regwrite_w_q   <= 1'b0;
         memtoreg_w_q   <= 1'b0;
         readdata_w_q   <= 32'd0;
         aluout_w_q     <= 32'd0;
         pc_w_q         <= 32'd0;
         wa3_w_q        <= 4'd0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         mem_req_q      <= mem_req_d;
         mem_we_q       <= mem_we_d;
         mem_addr_q     <= mem_addr_d;
         mem_wdata_q    <= mem_wdata_d;
         flags_q        <= flags_d;
         mem_err_q      <= mem_err_d;
         cap_pcsrc_q    <= cap_pcsrc_d;
         cap_regwrite_q <= cap_regwrite_d;
         cap_memtoreg_q <= cap_memtoreg_d;
         cap_pc_q       <= cap_pc_d;
         cap_wa3_q      <= cap_wa3_d;
         pcsrc_w_q      <= pcsrc_w_d;
         regwrite_w_q   <= regwrite_w_d;
         memtoreg_w_q   <= memtoreg_w_d;
         readdata_w_q   <= readdata_w_d;
         aluout_w_q     <= aluout_w_d;
         pc_w_q         <= pc_w_d;
         wa3_w_q        <= wa3_w_d;
      end
   end

   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign FlagsQ    = flags_q;
   assign mem_err   = mem_err_q;
   assign PCSrcW    = pcsrc_w_q;
   assign RegWriteW = regwrite_w_q;
   assign MemtoRegW = memtoreg_w_q;
   assign ReadDataW = readdata_w_q;
   assign ALUOutW   = aluout_w_q;
   assign PCW       = pc_w_q;
   assign WA3W      = wa3_w_q;

endmodule

// File: tb/tb_mem_stage_access.sv
// tb/tb_mem_stage_access.sv - directed and randomized instruction stream against a transaction-level model
// The bench plays both the upstream pipeline (holding inputs while stalled) and the data memory.
module tb_mem_stage_access;

   localparam int MAX_WAIT = 16;
   localparam int K_ALU = 0, K_LOAD = 1, K_STORE = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        PCSrcM, RegWriteM, MemtoRegM, MemWriteM, FlagsWriteM;
   logic [31:0] ALUOutM, WriteDataM, PCM;
   logic [3:0]  WA3M, CondM, ALUFlagsM;
   logic        mem_req, mem_we;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic        mem_ack;
   logic        stallM;
   logic [3:0]  FlagsQ;
   logic        PCSrcW, RegWriteW, MemtoRegW;
   logic [31:0] ReadDataW, ALUOutW, PCW;
   logic [3:0]  WA3W;
   logic        mem_err;

   int n_tests = 0;
   int n_fail  = 0;
   logic [3:0] m_flags = 4'd0;
   logic       m_err   = 1'b0;

   mem_stage_access #(.MAX_WAIT(MAX_WAIT)) dut (
      .clk(clk), .rst(rst),
      .PCSrcM(PCSrcM), .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM),
      .MemWriteM(MemWriteM), .FlagsWriteM(FlagsWriteM),
      .ALUOutM(ALUOutM), .WriteDataM(WriteDataM), .PCM(PCM), .WA3M(WA3M),
      .CondM(CondM), .ALUFlagsM(ALUFlagsM),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack), .stallM(stallM), .FlagsQ(FlagsQ),
      .PCSrcW(PCSrcW), .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW),
      .ReadDataW(ReadDataW), .ALUOutW(ALUOutW), .PCW(PCW), .WA3W(WA3W),
      .mem_err(mem_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   // ARM rule: odd codes negate the even-code predicate; 1111 never executes here.
   function automatic bit cond_pass(input logic [3:0] c, input logic [3:0] f);
      bit n, z, cf, v, base;
      n = f[3]; z = f[2]; cf = f[1]; v = f[0];
      case (c[3:1])
         3'd0: base = z;
         3'd1: base = cf;
         3'd2: base = n;
         3'd3: base = v;
         3'd4: base = cf && !z;
         3'd5: base = (n == v);
         3'd6: base = !z && (n == v);
         default: base = 1'b1;
      endcase
      if (c == 4'hF) return 1'b0;
      return c[0] ? !base : base;
   endfunction

   // Called just after a posedge; returns just after the edge where the instruction retires.
   // ack_lat: cycles after issue at which mem_ack is sampled; 0 means never acknowledge.
   task automatic run_instr(input logic [3:0] cond, input int kind, input logic rw, input logic pcs,
                            input logic fw, input logic [3:0] fl, input logic [31:0] alu,
                            input logic [31:0] wd, input int ack_lat);
      bit          pass, is_acc, acked;
      logic [31:0] pc, rd;
      logic [3:0]  wa3;
      pc = $urandom; wa3 = 4'($urandom);
      pass   = cond_pass(cond, m_flags);
      is_acc = pass && (kind != K_ALU);
      CondM = cond; RegWriteM = rw; PCSrcM = pcs; FlagsWriteM = fw; ALUFlagsM = fl;
      ALUOutM = alu; WriteDataM = wd; PCM = pc; WA3M = wa3;
      MemtoRegM = (kind == K_LOAD); MemWriteM = (kind == K_STORE);
      mem_ack = 1'($urandom); mem_rdata = $urandom;
      @(negedge clk);
      check("stall_idle", stallM, is_acc);
      check("req_idle", mem_req, 1'b0);
      @(posedge clk); #1;
      mem_ack = 1'b0;
      if (fw && pass) m_flags = fl;
      check("flags", FlagsQ, m_flags);
      if (!is_acc) begin
         check("regw", RegWriteW, rw && pass);
         check("pcsw", PCSrcW, pcs && pass);
         check("m2r", MemtoRegW, 1'b0);
         check("aluw", ALUOutW, alu);
         check("pcw", PCW, pc);
         check("wa3w", WA3W, wa3);
         check("rdw", ReadDataW, 32'd0);
         check("req_none", mem_req, 1'b0);
      end else begin
         check("req_issue", mem_req, 1'b1);
         check("we_issue", mem_we, kind == K_STORE);
         check("addr_issue", mem_addr, alu);
         if (kind == K_STORE) check("wdata_issue", mem_wdata, wd);
         check("regw_bubble", RegWriteW, 1'b0);
         acked = 1'b0;
         rd = 32'd0;
         for (int cyc = 1; cyc <= MAX_WAIT; cyc++) begin
            mem_rdata = $urandom;
            if (cyc == ack_lat) begin
               mem_ack = 1'b1;
               rd = mem_rdata;
            end
            @(negedge clk);
            check("stall_wait", stallM, 1'b1);
            check("addr_hold", mem_addr, alu);
            @(posedge clk); #1;
            acked   = mem_ack;
            mem_ack = 1'b0;
            if (acked) begin
               check("req_ack", mem_req, 1'b0);
               check("regw_ack", RegWriteW, rw);
               check("pcsw_ack", PCSrcW, pcs);
               check("m2r_ack", MemtoRegW, kind == K_LOAD);
               check("rdw_ack", ReadDataW, (kind == K_LOAD) ? rd : 32'd0);
               check("aluw_ack", ALUOutW, alu);
               check("pcw_ack", PCW, pc);
               check("wa3w_ack", WA3W, wa3);
               break;
            end else if (cyc == MAX_WAIT) begin
               m_err = 1'b1;
               check("req_timeout", mem_req, 1'b0);
               check("err_timeout", mem_err, 1'b1);
               check("regw_timeout", RegWriteW, 1'b0);
            end else begin
               check("req_wait", mem_req, 1'b1);
               check("regw_wait", RegWriteW, 1'b0);
            end
         end
      end
      check("err_sticky", mem_err, m_err);
   endtask

   initial begin
      rst = 1'b1;
      {PCSrcM, RegWriteM, MemtoRegM, MemWriteM, FlagsWriteM, mem_ack} = '0;
      ALUOutM = 0; WriteDataM = 0; PCM = 0; WA3M = 0; CondM = 4'hE; ALUFlagsM = 0; mem_rdata = 0;
      #3;
      check("rst_req", mem_req, 1'b0);
      check("rst_flags", FlagsQ, 4'd0);
      check("rst_wb", {RegWriteW, PCSrcW, MemtoRegW, WA3W}, 32'd0);
      check("rst_err", mem_err, 1'b0);
      @(posedge clk); #1;
      rst = 1'b0;

      // flags and condition
      run_instr(4'hE, K_ALU, 1'b0, 1'b0, 1'b1, 4'b0100, 32'h1, 32'h0, 0);
      run_instr(4'h1, K_ALU, 1'b1, 1'b0, 1'b0, 4'b0000, 32'h2, 32'h0, 0);
      run_instr(4'h0, K_ALU, 1'b1, 1'b1, 1'b0, 4'b0000, 32'hCAFE, 32'h0, 0);
      // load, ack 3 cycles after req
      run_instr(4'hE, K_LOAD, 1'b1, 1'b0, 1'b0, 4'b0000, 32'h100, 32'h0, 3);
      // back-to-back stores acked next cycle
      run_instr(4'hE, K_STORE, 1'b0, 1'b0, 1'b0, 4'b0000, 32'h200, 32'h12345678, 1);
      run_instr(4'hE, K_STORE, 1'b0, 1'b0, 1'b0, 4'b0000, 32'h204, 32'h9ABCDEF0, 1);
      // condition-failed store with cleared flags
      run_instr(4'hE, K_ALU, 1'b0, 1'b0, 1'b1, 4'b0000, 32'h3, 32'h0, 0);
      run_instr(4'h0, K_STORE, 1'b1, 1'b1, 1'b0, 4'b0000, 32'h300, 32'h55, 1);
      // timeout
      run_instr(4'hE, K_LOAD, 1'b1, 1'b0, 1'b0, 4'b0000, 32'h400, 32'h0, 0);
      run_instr(4'hE, K_ALU, 1'b1, 1'b0, 1'b0, 4'b0000, 32'h4, 32'h0, 0);

      for (int i = 0; i < 300; i++) begin
         int k, lat;
         k   = $urandom_range(0, 2);
         lat = ($urandom_range(0, 24) == 0) ? 0 : $urandom_range(1, 6);
         run_instr(4'($urandom), k, 1'($urandom), 1'($urandom), 1'($urandom), 4'($urandom),
                   $urandom, $urandom, lat);
      end

      // reset in the middle of an outstanding load
      CondM = 4'hE; MemtoRegM = 1'b1; MemWriteM = 1'b0; RegWriteM = 1'b1; PCSrcM = 1'b0;
      FlagsWriteM = 1'b1; ALUFlagsM = 4'b1010; ALUOutM = 32'h500; mem_ack = 1'b0;
      if (m_flags == 4'hF) CondM = 4'hE;
      @(posedge clk); #1;
      check("rw_issue_req", mem_req, 1'b1);
      check("rw_issue_flags", FlagsQ, 4'b1010);
      @(posedge clk); #1;
      @(posedge clk); #2;
      rst = 1'b1;
      #1;
      check("arst_req", mem_req, 1'b0);
      check("arst_flags", FlagsQ, 4'd0);
      check("arst_wb", {RegWriteW, PCSrcW, MemtoRegW, WA3W, PCW[15:0]}, 32'd0);
      check("arst_err", mem_err, 1'b0);
      m_flags = 4'd0;
      m_err   = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      run_instr(4'hE, K_ALU, 1'b1, 1'b0, 1'b0, 4'b0000, 32'h600, 32'h0, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
